// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue scheduler between the issue-queue register
// and execute; register scoreboard, in-flight count, priv serialization.
module issue_ctrl #(
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [1:0] in_slot_v,
  output logic       in_ready,
  input  logic       in_is_alu0,
  input  logic       in_is_alu1,
  input  logic       in_is_priv0,
  input  logic       in_is_priv1,
  input  logic       in_wen0,
  input  logic       in_wen1,
  input  logic [4:0] in_rd0,
  input  logic [4:0] in_rd1,
  input  logic [4:0] in_rj0,
  input  logic [4:0] in_rj1,
  input  logic [4:0] in_rk0,
  input  logic [4:0] in_rk1,
  input  logic       ex_ready,
  output logic       iss_valid0,
  output logic       iss_valid1,
  output logic       iss_sel,
  input  logic       wb_en0,
  input  logic       wb_en1,
  input  logic [4:0] wb_rd0,
  input  logic [4:0] wb_rd1,
  input  logic [1:0] retire_cnt
);

  typedef enum logic [1:0] {
    PAIR,
    SECOND,
    DRAIN
  } state_t;

  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_INFLIGHT);
  localparam logic [CNT_W:0] TWO_C = (CNT_W+1)'(2);

  state_t           state_q, state_d;
  logic [31:0]      busy_q, busy_d;
  logic [31:0]      set_v, clr_v;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dsec_q, dsec_d;
  logic [CNT_W:0]   cnt_x, sum, ret_x;
  logic             x_is1, x_v, x_wen, x_priv;
  logic [4:0]       x_rd, x_rj, x_rk;
  logic             hz_x, hz_1, pair_ok;
  logic             x_ok, dual_ok, last, fire;
  logic [1:0]       n_iss;
  logic             unused;

  // slot0's ALU class never restricts issue; only slot1 must be simple
  assign unused = in_is_alu0;

  assign cnt_x  = {1'b0, cnt_q};
  assign x_is1  = (state_q == SECOND) |
                  ((state_q == PAIR) & ~in_slot_v[0]);
  assign x_v    = x_is1 ? in_slot_v[1] : in_slot_v[0];
  assign x_wen  = x_is1 ? in_wen1 : in_wen0;
  assign x_priv = x_is1 ? in_is_priv1 : in_is_priv0;
  assign x_rd   = x_is1 ? in_rd1 : in_rd0;
  assign x_rj   = x_is1 ? in_rj1 : in_rj0;
  assign x_rk   = x_is1 ? in_rk1 : in_rk0;

  assign hz_x = busy_q[x_rj] | busy_q[x_rk] |
                (x_wen & busy_q[x_rd]);
  assign hz_1 = busy_q[in_rj1] | busy_q[in_rk1] |
                (in_wen1 & busy_q[in_rd1]);

  assign pair_ok = ~in_wen0 |
                   ((in_rj1 != in_rd0) & (in_rk1 != in_rd0) &
                    ~(in_wen1 & (in_rd1 == in_rd0)));

  assign x_ok = in_valid & x_v & (state_q != DRAIN) & ~hz_x &
                (cnt_x < MAX_C) & (~x_priv | (cnt_q == '0));

  assign dual_ok = x_ok & (state_q == PAIR) & (&in_slot_v) &
                   in_is_alu1 & ~in_is_priv0 & ~in_is_priv1 &
                   ~hz_1 & pair_ok & ((cnt_x + TWO_C) <= MAX_C);

  assign last = dual_ok | x_is1 | ~in_slot_v[1];

  // issue handshake outputs, forced quiet in reset and on flush
  always_comb begin
    iss_valid0 = 1'b0;
    iss_valid1 = 1'b0;
    iss_sel    = 1'b0;
    in_ready   = 1'b0;
    fire       = 1'b0;
    if (aresetn) begin
      iss_sel = x_is1;
      if (flush) begin
        in_ready = in_valid;
      end else begin
        iss_valid0 = x_ok;
        iss_valid1 = dual_ok;
        fire       = x_ok & ex_ready;
        in_ready   = fire & last;
      end
    end
  end

  // next scoreboard, in-flight count and scheduler state
  always_comb begin
    set_v = '0;
    clr_v = '0;
    n_iss = 2'd0;
    if (fire) n_iss = dual_ok ? 2'd2 : 2'd1;
    if (fire & x_wen & (|x_rd)) set_v[x_rd] = 1'b1;
    if (fire & dual_ok & in_wen1 & (|in_rd1))
      set_v[in_rd1] = 1'b1;
    if (wb_en0) clr_v[wb_rd0] = 1'b1;
    if (wb_en1) clr_v[wb_rd1] = 1'b1;
    sum     = cnt_x + {{(CNT_W-1){1'b0}}, n_iss};
    ret_x   = {{(CNT_W-1){1'b0}}, retire_cnt};
    busy_d  = (busy_q | set_v) & ~clr_v & ~32'd1;
    cnt_d   = (sum > ret_x) ? CNT_W'(sum - ret_x) : '0;
    state_d = state_q;
    dsec_d  = dsec_q;
    if (flush) begin
      state_d = PAIR;
      dsec_d  = 1'b0;
      busy_d  = '0;
      cnt_d   = '0;
    end else if (fire) begin
      if (x_priv) begin
        state_d = DRAIN;
        dsec_d  = ~x_is1 & in_slot_v[1];
      end else if (~x_is1 & ~dual_ok & in_slot_v[1]) begin
        state_d = SECOND;
      end else begin
        state_d = PAIR;
      end
    end else if ((state_q == DRAIN) & (cnt_q == '0)) begin
      state_d = dsec_q ? SECOND : PAIR;
      dsec_d  = 1'b0;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= PAIR;
      busy_q  <= '0;
      cnt_q   <= '0;
      dsec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      dsec_q  <= dsec_d;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scenarios then random traffic, checked
// against a slot-level reference model of the issue rules.
module tb_issue_ctrl;

  localparam int MAX = 8;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_slot_v = 2'd0;
  logic       in_ready;
  logic       in_is_alu0 = 1'b0, in_is_alu1 = 1'b0;
  logic       in_is_priv0 = 1'b0, in_is_priv1 = 1'b0;
  logic       in_wen0 = 1'b0, in_wen1 = 1'b0;
  logic [4:0] in_rd0 = 5'd0, in_rd1 = 5'd0;
  logic [4:0] in_rj0 = 5'd0, in_rj1 = 5'd0;
  logic [4:0] in_rk0 = 5'd0, in_rk1 = 5'd0;
  logic       ex_ready = 1'b1;
  logic       iss_valid0, iss_valid1, iss_sel;
  logic       wb_en0 = 1'b0, wb_en1 = 1'b0;
  logic [4:0] wb_rd0 = 5'd0, wb_rd1 = 5'd0;
  logic [1:0] retire_cnt = 2'd0;

  int checks = 0;
  int failures = 0;

  bit mbusy [32];
  int mcnt;
  bit mdone0, mdrain;
  bit e_iv0, e_iv1, e_sel, e_rdy;
  bit m_fire, m_dual, m_xwen, m_xpriv;
  logic [4:0] m_xrd;
  bit held;

  issue_ctrl #(.MAX_INFLIGHT(8), .CNT_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .in_valid(in_valid), .in_slot_v(in_slot_v),
    .in_ready(in_ready),
    .in_is_alu0(in_is_alu0), .in_is_alu1(in_is_alu1),
    .in_is_priv0(in_is_priv0), .in_is_priv1(in_is_priv1),
    .in_wen0(in_wen0), .in_wen1(in_wen1),
    .in_rd0(in_rd0), .in_rd1(in_rd1),
    .in_rj0(in_rj0), .in_rj1(in_rj1),
    .in_rk0(in_rk0), .in_rk1(in_rk1),
    .ex_ready(ex_ready),
    .iss_valid0(iss_valid0), .iss_valid1(iss_valid1),
    .iss_sel(iss_sel),
    .wb_en0(wb_en0), .wb_en1(wb_en1),
    .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
    .retire_cnt(retire_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mcnt = 0;
    mdone0 = 1'b0;
    mdrain = 1'b0;
  endtask

  // expected outputs from the pending-slot rules, then compare
  task automatic look();
    bit p1, xv, xok, hx, h1, indep;
    logic [4:0] xrj, xrk;
    p1 = mdone0 || !in_slot_v[0];
    xv = p1 ? in_slot_v[1] : in_slot_v[0];
    xrj = p1 ? in_rj1 : in_rj0;
    xrk = p1 ? in_rk1 : in_rk0;
    m_xrd = p1 ? in_rd1 : in_rd0;
    m_xwen = p1 ? in_wen1 : in_wen0;
    m_xpriv = p1 ? in_is_priv1 : in_is_priv0;
    hx = mbusy[xrj] || mbusy[xrk] || (m_xwen && mbusy[m_xrd]);
    h1 = mbusy[in_rj1] || mbusy[in_rk1] ||
         (in_wen1 && mbusy[in_rd1]);
    xok = in_valid && xv && !mdrain && !hx && mcnt < MAX &&
          (!m_xpriv || mcnt == 0);
    indep = !in_wen0 || (in_rj1 != in_rd0 && in_rk1 != in_rd0 &&
            !(in_wen1 && in_rd1 == in_rd0));
    m_dual = xok && !mdone0 && in_slot_v == 2'b11 && in_is_alu1 &&
             !in_is_priv0 && !in_is_priv1 && !h1 && indep &&
             mcnt + 2 <= MAX;
    e_iv0 = 0; e_iv1 = 0; e_sel = 0; e_rdy = 0; m_fire = 0;
    if (aresetn) begin
      e_sel = !mdrain && p1;
      if (flush) e_rdy = in_valid;
      else begin
        e_iv0 = xok;
        e_iv1 = m_dual;
        m_fire = xok && ex_ready;
        e_rdy = m_fire && (m_dual || p1 || !in_slot_v[1]);
      end
    end
    #3;
    chk("iss_valid0", iss_valid0, e_iv0);
    chk("iss_valid1", iss_valid1, e_iv1);
    chk("iss_sel", iss_sel, e_sel);
    chk("in_ready", in_ready, e_rdy);
  endtask

  // clock edge, then advance the model with this cycle's inputs
  task automatic tick();
    int old;
    @(posedge aclk);
    #1;
    if (!aresetn || flush) begin
      model_reset();
    end else begin
      old = mcnt;
      if (m_fire && m_xwen && m_xrd != 0) mbusy[m_xrd] = 1'b1;
      if (m_fire && m_dual && in_wen1 && in_rd1 != 0)
        mbusy[in_rd1] = 1'b1;
      if (wb_en0) mbusy[wb_rd0] = 1'b0;
      if (wb_en1) mbusy[wb_rd1] = 1'b0;
      mbusy[0] = 1'b0;
      mcnt = old + (m_fire ? (m_dual ? 2 : 1) : 0) - int'(retire_cnt);
      if (mcnt < 0) mcnt = 0;
      if (m_fire) begin
        mdone0 = !e_rdy;
        if (m_xpriv) mdrain = 1'b1;
      end else if (mdrain && old == 0) begin
        mdrain = 1'b0;
      end
    end
  endtask

  task automatic set_pair(
    input logic [1:0] v, input logic a1, p0, p1,
    input logic w0, input logic [4:0] d0, j0, k0,
    input logic w1, input logic [4:0] d1, j1, k1);
    in_valid = 1'b1;
    in_slot_v = v;
    in_is_alu0 = 1'b1;
    in_is_alu1 = a1;
    in_is_priv0 = p0; in_is_priv1 = p1;
    in_wen0 = w0; in_rd0 = d0; in_rj0 = j0; in_rk0 = k0;
    in_wen1 = w1; in_rd1 = d1; in_rj1 = j1; in_rk1 = k1;
  endtask

  task automatic rand_pair();
    logic [1:0] v;
    v = 2'($urandom_range(1, 3));
    set_pair(v, 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
  endtask

  initial begin
    logic [4:0] r;
    model_reset();
    #1;
    // reset holds every output low
    set_pair(2'b11, 1, 0, 0, 1, 1, 3, 4, 1, 2, 5, 6);
    look();
    chk("rst_iv0", iss_valid0, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    tick();
    aresetn = 1'b1;
    // independent pair issues dual
    look();
    chk("dual_iv0", iss_valid0, 1'b1);
    chk("dual_iv1", iss_valid1, 1'b1);
    chk("dual_rdy", in_ready, 1'b1);
    tick();
    set_pair(2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    look();
    chk("busy1_stall", iss_valid0, 1'b0);
    tick();
    wb_en0 = 1; wb_rd0 = 1; wb_en1 = 1; wb_rd1 = 2; retire_cnt = 2;
    look();
    chk("wb_same_cycle", iss_valid0, 1'b0);
    tick();
    wb_en0 = 0; wb_en1 = 0; retire_cnt = 0;
    look();
    chk("busy1_free", iss_valid0, 1'b1);
    tick();
    // intra-pair RAW splits the pair
    set_pair(2'b11, 1, 0, 0, 1, 5, 3, 4, 1, 6, 5, 7);
    retire_cnt = 1;
    look();
    chk("raw_iv0", iss_valid0, 1'b1);
    chk("raw_iv1", iss_valid1, 1'b0);
    chk("raw_sel", iss_sel, 1'b0);
    chk("raw_rdy", in_ready, 1'b0);
    tick();
    retire_cnt = 0;
    look();
    chk("raw_hold", iss_valid0, 1'b0);
    chk("raw_sel2", iss_sel, 1'b1);
    tick();
    wb_en0 = 1; wb_rd0 = 5;
    look();
    tick();
    wb_en0 = 0;
    look();
    chk("raw_go", iss_valid0, 1'b1);
    chk("raw_go_rdy", in_ready, 1'b1);
    tick();
    in_valid = 0; wb_en0 = 1; wb_rd0 = 6; retire_cnt = 2;
    look();
    tick();
    wb_en0 = 0; retire_cnt = 0;
    // priv waits for an empty pipeline, then drains
    set_pair(2'b11, 1, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4);
    look(); tick();
    set_pair(2'b01, 1, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4);
    look(); tick();
    set_pair(2'b11, 1, 1, 0, 0, 0, 1, 2, 0, 0, 3, 4);
    look();
    chk("priv_wait", iss_valid0, 1'b0);
    tick();
    retire_cnt = 1;
    repeat (3) begin
      look();
      chk("priv_cnt", iss_valid0, 1'b0);
      tick();
    end
    retire_cnt = 0;
    look();
    chk("priv_iv0", iss_valid0, 1'b1);
    chk("priv_iv1", iss_valid1, 1'b0);
    chk("priv_rdy", in_ready, 1'b0);
    tick();
    retire_cnt = 1;
    look();
    chk("drain_hold", iss_valid0, 1'b0);
    tick();
    retire_cnt = 0;
    look(); tick();
    look();
    chk("drain_sec", iss_valid0, 1'b1);
    chk("drain_sel", iss_sel, 1'b1);
    tick();
    // count 7 allows only one more issue
    repeat (3) begin
      set_pair(2'b11, 1, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4);
      look(); tick();
    end
    set_pair(2'b11, 1, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4);
    look();
    chk("c7_iv0", iss_valid0, 1'b1);
    chk("c7_iv1", iss_valid1, 1'b0);
    chk("c7_rdy", in_ready, 1'b0);
    tick();
    look();
    chk("c8_stall", iss_valid0, 1'b0);
    tick();
    retire_cnt = 2;
    look(); tick();
    retire_cnt = 0;
    look();
    chk("c6_go", iss_valid0, 1'b1);
    tick();
    // back-pressure leaves count and scoreboard alone
    set_pair(2'b01, 0, 0, 0, 1, 9, 1, 2, 0, 0, 0, 0);
    ex_ready = 0;
    repeat (2) begin
      look();
      chk("bp_iv0", iss_valid0, 1'b1);
      chk("bp_rdy", in_ready, 1'b0);
      tick();
    end
    ex_ready = 1;
    look();
    chk("bp_go", in_ready, 1'b1);
    tick();
    // flush in SECOND clears everything
    in_valid = 0; retire_cnt = 2; wb_en0 = 1; wb_rd0 = 9;
    look(); tick();
    wb_en0 = 0;
    look(); tick();
    set_pair(2'b11, 1, 0, 0, 1, 5, 1, 2, 1, 6, 5, 3);
    retire_cnt = 1;
    look(); tick();
    retire_cnt = 0;
    flush = 1;
    look();
    chk("fl_iv0", iss_valid0, 1'b0);
    chk("fl_rdy", in_ready, 1'b1);
    tick();
    flush = 0;
    set_pair(2'b01, 0, 1, 0, 0, 0, 5, 5, 0, 0, 0, 0);
    look();
    chk("fl_clean", iss_valid0, 1'b1);
    chk("fl_sel", iss_sel, 1'b0);
    tick();
    // reset while draining
    aresetn = 0;
    look(); tick();
    aresetn = 1;
    in_valid = 0;
    look(); tick();
    // random traffic
    held = 0;
    repeat (3000) begin
      if (!held) begin
        rand_pair();
        in_valid = ($urandom_range(0, 3) != 0);
        held = in_valid;
      end
      ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      aresetn = ($urandom_range(0, 299) != 0);
      r = 5'($urandom_range(1, 7));
      wb_rd0 = r;
      wb_en0 = mbusy[r] && ($urandom_range(0, 1) == 1);
      r = 5'($urandom_range(1, 7));
      wb_rd1 = r;
      wb_en1 = mbusy[r] && ($urandom_range(0, 1) == 1);
      if (mcnt == 0 && $urandom_range(0, 9) != 0) retire_cnt = 0;
      else retire_cnt = 2'($urandom_range(0, 2));
      look();
      tick();
      if (e_rdy) held = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Dual-issue scheduler between the decode/issue-queue pipeline register and the execute stage. Each cycle it takes the held instruction pair and decides whether to issue both, only the oldest pending slot, or neither. The decision uses a 32-entry register scoreboard, an in-flight counter, intra-pair hazard checks and serialization of privileged/syscall/break instructions. A pair may be split across cycles; the upstream register is released only after its last valid slot has issued.

Parameters:
MAX_INFLIGHT, 8, maximum issued-but-not-retired instructions
CNT_W, 4, in-flight counter width; must hold MAX_INFLIGHT

Ports:
aclk  in  1  clock
aresetn  in  1  reset; synchronous, active-low; clock aclk
flush  in  1  pipeline flush (exception/branch redirect)
in_valid  in  1  pair held upstream is valid
in_slot_v  in  2  per-slot valid (bit0 = older)
in_ready  out  1  pair consumed this cycle
in_is_alu0/1  in  1 each  slot is a simple ALU op
in_is_priv0/1  in  1 each  privileged, syscall or break
in_wen0/1  in  1 each  slot writes rd
in_rd0/1, in_rj0/1, in_rk0/1  in  5 each  register indices
ex_ready  in  1  execute stage accepts an issue bundle
iss_valid0, iss_valid1  out  1 each  issue lane valid
iss_sel  out  1  lane0 carries input slot1 (split second half)
wb_en0/1  in  1 each  writeback releases wb_rd0/1
wb_rd0/1  in  5 each  writeback register
retire_cnt  in  2  instructions retired this cycle (0..2)

Behaviour:
- State: PAIR (slot0 pending, or slot0 invalid and slot1 pending), SECOND (slot0 issued, slot1 pending), DRAIN (priv issued, waiting for the in-flight count to reach 0). Reset: PAIR, busy = 0, count = 0. While aresetn is low, all outputs are 0.
- Oldest pending slot X = slot0 in PAIR if in_slot_v[0]=1, else slot1. X may issue when:
  - busy[rjX] = 0, busy[rkX] = 0, and busy[rdX] = 0 if wenX (RAW/WAW);
  - count < MAX_INFLIGHT;
  - if privX: count = 0.
  - Index 0 is never busy.
- Dual issue (PAIR, both slots valid) additionally requires:
  - in_is_alu1 = 1;
  - neither slot is priv;
  - slot1 has no busy hazard;
  - if wen0: rj1 != rd0, rk1 != rd0, and not (wen1 and rd1 = rd0);
  - count + 2 <= MAX_INFLIGHT.
- Outputs are combinational from state and inputs. iss_valid0 = in_valid and X eligible. iss_valid1 = dual eligible. iss_sel = 1 in SECOND, or in PAIR when slot0 is invalid.
- Fire = iss_valid0 and ex_ready. Lanes fire together; no partial acceptance.
- On fire:
  - set busy[rd] for each issued slot with wen and rd != 0;
  - count <= count + issued − retire_cnt;
  - next state: DRAIN if a priv slot issued; else SECOND if slot0 issued alone and slot1 valid; else PAIR.
- in_ready = 1 on the fire that issues the last valid slot of the pair. The upstream register must hold the pair stable while in_ready = 0.
- DRAIN: no issue and in_ready = 0 while count != 0. Return to PAIR the cycle after count reaches 0; if the priv slot was slot0 and slot1 is valid, go to SECOND instead.
  - in_ready for the priv pair is asserted at fire when the priv slot is the last valid slot.
- Writeback: clear busy[wb_rdN] when wb_enN. A same-cycle set and clear of the same index cannot occur, because issue requires busy = 0 on the registered view (no bypass).
- count updates every cycle by −retire_cnt even without a fire. Underflow is an integration error; saturate at 0.
- flush, highest priority: iss_valid0/1 = 0; in_ready = in_valid (discard the pair); next cycle state = PAIR, busy = 0, count = 0. Any writeback or retire in the flush cycle is ignored.
- Reset mid-split or mid-drain returns to PAIR with no issue.
- Latency: issue decision is the same cycle; scoreboard/count effects are visible the next cycle.

Test Plan:
- Independent ALU pair (rd0=1, rd1=2, sources 3–6), ex_ready=1 → iss_valid0=iss_valid1=1 and in_ready=1 in one cycle; busy[1], busy[2] set; count=2.
- Intra-pair RAW: slot0 wen rd=5, slot1 rj=5 → cycle1: only lane0 issues, in_ready=0, iss_sel=0. Cycle2 (busy[5] set until wb): stall. After wb_en0 with wb_rd0=5 → slot1 issues with iss_sel=1 and in_ready=1.
- Priv slot0 with count=3 → stall until retire_cnt drains count to 0. Then the priv issues alone and state is DRAIN. After retire_cnt=1, slot1 issues the following cycle.
- count=7 with MAX_INFLIGHT=8 → a dual-eligible pair issues only lane0; the pair is split.
- ex_ready=0 with an eligible pair → iss_valid held high, in_ready=0, busy and count unchanged.
- flush in SECOND with busy[5]=1 and count=4 → in_ready=1 and no issue; next cycle state is PAIR, busy=0, count=0.
